simmem_row_scheduler: RTL and testbench



---
 rtl/simmem_pkg.sv | 44 ++++
 rtl/simmem_row_cost.sv | 36 +++
 rtl/simmem_row_scheduler.sv | 143 ++++++++++++++
 tb/tb_simmem_row_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simmem_pkg;

    localparam int unsigned IDWidth           = 4;
    localparam int unsigned AxAddrWidth       = 16;
    localparam int unsigned RowBufferLenWidth = 8;
    localparam int unsigned BurstLenWidth     = 8;
    localparam int unsigned BurstSizeWidth    = 3;
    localparam int unsigned BurstTypeWidth    = 2;

    // DRAM timing costs, in core cycles.
    localparam int unsigned RowHitCost     = 10;
    localparam int unsigned ActivationCost = 45;
    localparam int unsigned PrechargeCost  = 50;

    // Wide enough for PrechargeCost + ActivationCost + RowHitCost + 255 beats.
    localparam int unsigned CostWidth = 9;
    localparam int unsigned RowWidth  = AxAddrWidth - RowBufferLenWidth;

    typedef struct packed {
        logic [IDWidth-1:0]        id;
        logic [AxAddrWidth-1:0]    addr;
        logic [BurstLenWidth-1:0]  burst_length;
        logic [BurstSizeWidth-1:0] burst_size;
        logic [BurstTypeWidth-1:0] burst_type;
    } waddr_req_t;

    typedef struct packed {
        logic [IDWidth-1:0]        id;
        logic [AxAddrWidth-1:0]    addr;
        logic [BurstLenWidth-1:0]  burst_length;
        logic [BurstSizeWidth-1:0] burst_size;
        logic [BurstTypeWidth-1:0] burst_type;
    } raddr_req_t;

    typedef enum logic [1:0] {
        RowIdle    = 2'd0,
        RowService = 2'd1,
        RowReport  = 2'd2
    } row_state_e;

endpackage

// File: rtl/simmem_row_cost.sv
// Service cost of one request against the single-bank row buffer.
// Latency: purely combinational.
// Backpressure: none; ports: row state + addr + burst_length in, cost_o out.
module simmem_row_cost
    import simmem_pkg::*;
#(
    parameter int unsigned BeatCost  = 1,
    parameter int unsigned CostWidth = simmem_pkg::CostWidth
) (
    input  logic                     row_open_i,
    input  logic [RowWidth-1:0]      open_row_i,
    input  logic [AxAddrWidth-1:0]   addr_i,
    input  logic [BurstLenWidth-1:0] burst_length_i,
    output logic [CostWidth-1:0]     cost_o
);

    logic [RowWidth-1:0]  req_row;
    logic [CostWidth-1:0] base_cost;
    logic [CostWidth-1:0] beat_cost;

    assign req_row = addr_i[AxAddrWidth-1:RowBufferLenWidth];

    always_comb begin
        base_cost = CostWidth'(PrechargeCost + ActivationCost + RowHitCost);
        if (!row_open_i) begin
            base_cost = CostWidth'(ActivationCost + RowHitCost);
        end else if (open_row_i == req_row) begin
            base_cost = CostWidth'(RowHitCost);
        end
    end

    // Zero-extended, no saturation: CostWidth is sized for the worst case.
    assign beat_cost = CostWidth'(burst_length_i) * CostWidth'(BeatCost);
    assign cost_o    = base_cost + beat_cost;

endmodule

// File: rtl/simmem_row_scheduler.sv
// Round-robin write/read address arbiter with a one-bank row-buffer timing model.
// Latency: done_valid_o rises exactly <cost> cycles after the accept edge.
// Backpressure: one request in flight; readies low until done handshake (done_ready_i stalls REPORT).
module simmem_row_scheduler
    import simmem_pkg::*;
#(
    parameter int unsigned BeatCost  = 1,
    parameter int unsigned CostWidth = simmem_pkg::CostWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  waddr_req_t           waddr_i,
    input  logic                 waddr_valid_i,
    output logic                 waddr_ready_o,
    input  raddr_req_t           raddr_i,
    input  logic                 raddr_valid_i,
    output logic                 raddr_ready_o,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic [IDWidth-1:0]   done_id_o,
    output logic                 done_is_write_o,
    output logic [CostWidth-1:0] done_cost_o,
    output logic                 row_open_o,
    output logic [RowWidth-1:0]  open_row_o
);

    row_state_e           state_q, state_d;
    logic [CostWidth-1:0] cnt_q, cnt_d;
    logic                 last_was_write_q, last_was_write_d;
    logic                 row_open_q, row_open_d;
    logic [RowWidth-1:0]  open_row_q, open_row_d;
    logic [IDWidth-1:0]   done_id_q, done_id_d;
    logic                 done_is_write_q, done_is_write_d;
    logic [CostWidth-1:0] done_cost_q, done_cost_d;

    logic                     grant_w;
    logic                     grant_r;
    logic [AxAddrWidth-1:0]   sel_addr;
    logic [BurstLenWidth-1:0] sel_len;
    logic [IDWidth-1:0]       sel_id;
    logic [CostWidth-1:0]     sel_cost;

    logic unused_req_fields;
    assign unused_req_fields = ^{waddr_i.burst_size, waddr_i.burst_type,
                                 raddr_i.burst_size, raddr_i.burst_type};

    // Both valid: alternate away from the last winner. Single valid: it wins.
    assign grant_w = waddr_valid_i && (!raddr_valid_i || !last_was_write_q);
    assign grant_r = raddr_valid_i && !grant_w;

    assign sel_addr = grant_w ? waddr_i.addr         : raddr_i.addr;
    assign sel_len  = grant_w ? waddr_i.burst_length : raddr_i.burst_length;
    assign sel_id   = grant_w ? waddr_i.id           : raddr_i.id;

    simmem_row_cost #(
        .BeatCost  (BeatCost),
        .CostWidth (CostWidth)
    ) u_row_cost (
        .row_open_i     (row_open_q),
        .open_row_i     (open_row_q),
        .addr_i         (sel_addr),
        .burst_length_i (sel_len),
        .cost_o         (sel_cost)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        last_was_write_d = last_was_write_q;
        row_open_d       = row_open_q;
        open_row_d       = open_row_q;
        done_id_d        = done_id_q;
        done_is_write_d  = done_is_write_q;
        done_cost_d      = done_cost_q;
        waddr_ready_o    = 1'b0;
        raddr_ready_o    = 1'b0;

        unique case (state_q)
            RowIdle: begin
                // Readies are gated by reset so nothing is granted while held in reset.
                waddr_ready_o = grant_w && rst_ni;
                raddr_ready_o = grant_r && rst_ni;
                if (grant_w || grant_r) begin
                    state_d          = RowService;
                    // SERVICE occupies cost-1 cycles, so REPORT lands in cycle <cost>.
                    cnt_d            = sel_cost - CostWidth'(1);
                    last_was_write_d = grant_w;
                    row_open_d       = 1'b1;
                    open_row_d       = sel_addr[AxAddrWidth-1:RowBufferLenWidth];
                    done_id_d        = sel_id;
                    done_is_write_d  = grant_w;
                    done_cost_d      = sel_cost;
                end
            end
            RowService: begin
                if (cnt_q <= CostWidth'(1)) begin
                    state_d = RowReport;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CostWidth'(1);
                end
            end
            RowReport: begin
                if (done_ready_i) begin
                    state_d = RowIdle;
                end
            end
            default: begin
                state_d = RowIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= RowIdle;
            cnt_q            <= '0;
            last_was_write_q <= 1'b0;
            row_open_q       <= 1'b0;
            open_row_q       <= '0;
            done_id_q        <= '0;
            done_is_write_q  <= 1'b0;
            done_cost_q      <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_was_write_q <= last_was_write_d;
            row_open_q       <= row_open_d;
            open_row_q       <= open_row_d;
            done_id_q        <= done_id_d;
            done_is_write_q  <= done_is_write_d;
            done_cost_q      <= done_cost_d;
        end
    end

    assign done_valid_o    = (state_q == RowReport);
    assign done_id_o       = done_id_q;
    assign done_is_write_o = done_is_write_q;
    assign done_cost_o     = done_cost_q;
    assign row_open_o      = row_open_q;
    assign open_row_o      = open_row_q;

endmodule

// File: tb/tb_simmem_row_scheduler.sv
module tb_simmem_row_scheduler;
    import simmem_pkg::*;

    logic                 clk;
    logic                 rst_n;
    waddr_req_t           waddr;
    logic                 waddr_valid;
    logic                 waddr_ready;
    raddr_req_t           raddr;
    logic                 raddr_valid;
    logic                 raddr_ready;
    logic                 done_valid;
    logic                 done_ready;
    logic [IDWidth-1:0]   done_id;
    logic                 done_is_write;
    logic [CostWidth-1:0] done_cost;
    logic                 row_open;
    logic [RowWidth-1:0]  open_row;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    simmem_row_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .waddr_i         (waddr),
        .waddr_valid_i   (waddr_valid),
        .waddr_ready_o   (waddr_ready),
        .raddr_i         (raddr),
        .raddr_valid_i   (raddr_valid),
        .raddr_ready_o   (raddr_ready),
        .done_valid_o    (done_valid),
        .done_ready_i    (done_ready),
        .done_id_o       (done_id),
        .done_is_write_o (done_is_write),
        .done_cost_o     (done_cost),
        .row_open_o      (row_open),
        .open_row_o      (open_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the block in IDLE. Presents one request, lets it be
    // accepted on the next posedge (cycle 0), then counts cycles until done_valid.
    task automatic run_req(input bit is_w, input int id, input int addr, input int len,
                           output int cyc);
        if (is_w) begin
            waddr.id           = IDWidth'(id);
            waddr.addr         = AxAddrWidth'(addr);
            waddr.burst_length = BurstLenWidth'(len);
            waddr_valid        = 1'b1;
        end else begin
            raddr.id           = IDWidth'(id);
            raddr.addr         = AxAddrWidth'(addr);
            raddr.burst_length = BurstLenWidth'(len);
            raddr_valid        = 1'b1;
        end
        #1;
        chk("accept_ready", (is_w ? waddr_ready : raddr_ready), 1'b1);
        @(posedge clk);
        @(negedge clk);
        waddr_valid = 1'b0;
        raddr_valid = 1'b0;
        cyc = 1;
        while (!done_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_not_expired", (cyc < 500), 1'b1);
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  cyc;
        int  ng;
        int  both;
        bit  g[4];
        bit  saw_done;

        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        waddr       = '0;
        raddr       = '0;
        waddr_valid = 1'b0;
        raddr_valid = 1'b0;
        done_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_id", done_id, 4'd0);
        chk("rst_done_cost", done_cost, 9'd0);
        chk("rst_row_open", row_open, 1'b0);
        chk("rst_open_row", open_row, 8'd0);
        chk("rst_wready", waddr_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss: 45 + 10 + 0
        run_req(1'b0, 1, 'h0100, 0, cyc);
        chk("cold_cycle", cyc, 55);
        chk("cold_id", done_id, 4'd1);
        chk("cold_is_write", done_is_write, 1'b0);
        chk("cold_cost", done_cost, 9'd55);
        chk("cold_row_open", row_open, 1'b1);
        chk("cold_open_row", open_row, 8'h01);
        handshake();
        chk("cold_done_cleared", done_valid, 1'b0);

        // Row hit with 3 extra beats: 10 + 3
        run_req(1'b0, 2, 'h01FF, 3, cyc);
        chk("hit_cycle", cyc, 13);
        chk("hit_id", done_id, 4'd2);
        chk("hit_cost", done_cost, 9'd13);
        chk("hit_open_row", open_row, 8'h01);
        handshake();

        // Row conflict: 50 + 45 + 10
        run_req(1'b1, 3, 'h0200, 0, cyc);
        chk("conf_cycle", cyc, 105);
        chk("conf_is_write", done_is_write, 1'b1);
        chk("conf_cost", done_cost, 9'd105);
        chk("conf_open_row", open_row, 8'h02);
        handshake();

        // Worst case: conflict plus 255 beats = 360
        run_req(1'b1, 4, 'h0300, 255, cyc);
        chk("max_cycle", cyc, 360);
        chk("max_cost", done_cost, 9'd360);
        chk("max_open_row", open_row, 8'h03);
        handshake();

        // Backpressure: hold REPORT with a write waiting
        run_req(1'b0, 5, 'h0310, 2, cyc);
        chk("bp_cycle", cyc, 12);
        waddr.id           = 4'd6;
        waddr.addr         = 16'h0320;
        waddr.burst_length = 8'd0;
        waddr_valid        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", done_valid, 1'b1);
            chk("bp_id_stable", done_id, 4'd5);
            chk("bp_cost_stable", done_cost, 9'd12);
            chk("bp_wready_low", waddr_ready, 1'b0);
            chk("bp_rready_low", raddr_ready, 1'b0);
        end
        done_ready = 1'b1;
        #1;
        chk("bp_wready_in_hs", waddr_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        chk("bp_next_accept", waddr_ready, 1'b1);
        chk("bp_done_dropped", done_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        waddr_valid = 1'b0;
        cyc = 1;
        while (!done_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_wait_not_expired", (cyc < 500), 1'b1);
        chk("bp_after_cycle", cyc, 10);
        chk("bp_after_id", done_id, 4'd6);
        handshake();

        // Round-robin with both channels continuously valid
        do_reset();
        waddr.id = 4'd7; waddr.addr = 16'h0400; waddr.burst_length = 8'd0;
        raddr.id = 4'd8; raddr.addr = 16'h0400; raddr.burst_length = 8'd0;
        waddr_valid = 1'b1;
        raddr_valid = 1'b1;
        done_ready  = 1'b1;
        ng   = 0;
        both = 0;
        for (int c = 0; c < 600 && ng < 4; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (waddr_ready && raddr_ready) both++;
            if (waddr_ready) begin g[ng] = 1'b1; ng++; end
            else if (raddr_ready) begin g[ng] = 1'b0; ng++; end
        end
        chk("rr_grant_count", ng, 4);
        chk("rr_never_both", both, 0);
        chk("rr_grant0_w", g[0], 1'b1);
        chk("rr_grant1_r", g[1], 1'b0);
        chk("rr_grant2_w", g[2], 1'b1);
        chk("rr_grant3_r", g[3], 1'b0);
        waddr_valid = 1'b0;
        raddr_valid = 1'b0;
        done_ready  = 1'b0;

        // Reset during a 105-cycle conflict request
        do_reset();
        run_req(1'b0, 9, 'h0100, 0, cyc);
        chk("mr_warm_cycle", cyc, 55);
        handshake();
        waddr.id = 4'd10; waddr.addr = 16'h0200; waddr.burst_length = 8'd0;
        waddr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        waddr_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mr_done_valid", done_valid, 1'b0);
        chk("mr_done_id", done_id, 4'd0);
        chk("mr_is_write", done_is_write, 1'b0);
        chk("mr_done_cost", done_cost, 9'd0);
        chk("mr_row_open", row_open, 1'b0);
        chk("mr_open_row", open_row, 8'd0);
        chk("mr_wready", waddr_ready, 1'b0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_valid) saw_done = 1'b1;
        end
        chk("mr_no_completion", saw_done, 1'b0);
        chk("mr_row_still_closed", row_open, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
